// File: rtl/dom_out_sched_if.sv
// Bundle between the per-block output FIFOs, the round-robin scheduler and
// the downstream domain-conversion stage.
//
// Handshake: a FIFO is popped on a cycle where blk_valid[k] && blk_ready[k];
// a downstream beat transfers on a cycle where valid_o && ready_o. Once
// valid_o is raised, every beat field except FDSTI_o_all is held stable until
// ready_o is seen high.
interface dom_out_sched_if #(
    parameter int FIFO_NUM_O_BLK = 4,
    parameter int I_DATA_WIDTH   = 32,
    parameter int I_SSI_WIDTH    = 8,
    parameter int I_FDSSI_WIDTH  = 2,
    parameter int I_SAM_OFFSET   = 6
);
    logic [FIFO_NUM_O_BLK-1:0]              blk_valid;
    logic [FIFO_NUM_O_BLK-1:0]              blk_ready;
    logic [FIFO_NUM_O_BLK*I_DATA_WIDTH-1:0] blk_data;
    logic [FIFO_NUM_O_BLK*I_SSI_WIDTH-1:0]  blk_ssi;
    logic                                   valid_o;
    logic                                   wt_o;
    logic [I_FDSSI_WIDTH-1:0]               FDSSI_o;
    logic [FIFO_NUM_O_BLK-1:0]              FDSTI_o_all;
    logic [I_SSI_WIDTH-1:0]                 SSI_o;
    logic [I_SAM_OFFSET-1:0]                s_o;
    logic                                   ready_o;
    logic [I_DATA_WIDTH-1:0]                data_o;

    // Scheduler side
    modport master (
        input  blk_valid, blk_data, blk_ssi, ready_o,
        output blk_ready, valid_o, wt_o, FDSSI_o, FDSTI_o_all, SSI_o, s_o, data_o
    );

    // FIFO / downstream side
    modport slave (
        output blk_valid, blk_data, blk_ssi, ready_o,
        input  blk_ready, valid_o, wt_o, FDSSI_o, FDSTI_o_all, SSI_o, s_o, data_o
    );
endinterface

// File: rtl/dom_out_sched.sv
// Round-robin output scheduler: grants one source FIFO at a time for a whole
// burst of SAM_PER_BLK samples and tags each beat with source index, stream
// ID, sample offset and a last-of-block flag through one output register.
module dom_out_sched #(
    parameter int FIFO_NUM_O_BLK = 4,
    parameter int I_DATA_WIDTH   = 32,
    parameter int I_SSI_WIDTH    = 8,
    parameter int I_FDSSI_WIDTH  = 2,
    parameter int I_SAM_OFFSET   = 6,
    parameter int SAM_PER_BLK    = 64
) (
    input  logic           clk,
    input  logic           rst,
    dom_out_sched_if.master bus,
    output logic           fsm_state   // 0 = IDLE, 1 = BURST
);
    localparam logic [I_SAM_OFFSET-1:0] LAST_CNT = I_SAM_OFFSET'(SAM_PER_BLK - 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                   st;
    logic [I_FDSSI_WIDTH-1:0] rr_ptr;
    logic [I_FDSSI_WIDTH-1:0] grant;
    logic [I_SSI_WIDTH-1:0]   ssi_q;
    logic [I_SAM_OFFSET-1:0]  cnt;

    logic                     load_en;
    logic                     pop;
    logic                     found;
    logic [I_FDSSI_WIDTH-1:0] winner;
    logic [I_FDSSI_WIDTH-1:0] grant_next;

    // The output register may be refilled when empty or being drained.
    assign load_en   = !bus.valid_o || bus.ready_o;
    assign pop       = (st == BURST) && load_en && bus.blk_valid[grant];
    assign fsm_state = (st == BURST);

    // Pointer that the next arbitration starts from once this burst ends.
    assign grant_next = (int'(grant) == FIFO_NUM_O_BLK - 1) ? '0 : grant + 1'b1;

    // Round-robin search: first valid FIFO at or after rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        for (int i = 0; i < FIFO_NUM_O_BLK; i++) begin
            if (!found && bus.blk_valid[(int'(rr_ptr) + i) % FIFO_NUM_O_BLK]) begin
                found  = 1'b1;
                winner = I_FDSSI_WIDTH'((int'(rr_ptr) + i) % FIFO_NUM_O_BLK);
            end
        end
    end

    // Pop strobe goes only to the granted FIFO, only while bursting.
    always_comb begin
        bus.blk_ready = '0;
        if (pop) begin
            bus.blk_ready[grant] = 1'b1;
        end
    end

    // Arbitration FSM, burst counter and the single output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st              <= IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            ssi_q           <= '0;
            cnt             <= '0;
            bus.valid_o     <= 1'b0;
            bus.wt_o        <= 1'b0;
            bus.FDSSI_o     <= '0;
            bus.FDSTI_o_all <= '0;
            bus.SSI_o       <= '0;
            bus.s_o         <= '0;
            bus.data_o      <= '0;
        end else begin
            bus.FDSTI_o_all <= bus.blk_valid;
            case (st)
                IDLE: begin
                    // Last beat of the previous block drains here; no pop in IDLE.
                    if (load_en) begin
                        bus.valid_o <= 1'b0;
                    end
                    if (found) begin
                        grant <= winner;
                        ssi_q <= bus.blk_ssi[int'(winner)*I_SSI_WIDTH +: I_SSI_WIDTH];
                        st    <= BURST;
                    end
                end
                BURST: begin
                    if (pop) begin
                        bus.valid_o <= 1'b1;
                        bus.data_o  <= bus.blk_data[int'(grant)*I_DATA_WIDTH +: I_DATA_WIDTH];
                        bus.FDSSI_o <= grant;
                        bus.SSI_o   <= ssi_q;
                        bus.s_o     <= cnt;
                        bus.wt_o    <= (cnt == LAST_CNT);
                        if (cnt == LAST_CNT) begin
                            cnt    <= '0;
                            rr_ptr <= grant_next;
                            st     <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (load_en) begin
                        // Granted FIFO empty: emit a bubble and keep waiting.
                        bus.valid_o <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
